// File: rtl/bec_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bec_arbiter_pkg
// Description : Shared types and sizes for the BEC engine arbiter.
// Revision    : 1.0
// ============================================================================
package bec_arbiter_pkg;

    localparam int c_NUM_REQ = 4;
    localparam int c_ID_W    = 2;
    localparam int c_X_W     = 18;
    localparam int c_Y_W     = 39;
    localparam int c_TMR_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bec_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : bec_rr_pick
// Description : Combinational 4-way round-robin picker starting at ptr.
// Revision    : 1.0
// ============================================================================
module bec_rr_pick
    import bec_arbiter_pkg::*;
(
    input  logic [c_NUM_REQ-1:0] req,
    input  logic [c_ID_W-1:0]    ptr,
    output logic [c_ID_W-1:0]    winner,
    output logic                 any
);

    logic [c_ID_W-1:0] w_idx;

    always_comb begin
        winner = ptr;
        any    = 1'b0;
        w_idx  = ptr;
        // Scan from the farthest slot back toward ptr so the nearest requester wins.
        for (int i = c_NUM_REQ - 1; i >= 0; i--) begin
            w_idx = ptr + c_ID_W'(i);
            if (req[w_idx]) begin
                winner = w_idx;
                any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bec_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bec_arbiter
// Description : Round-robin arbiter sharing one control engine among four
//               requesters, with per-job timeout and held response.
// Revision    : 1.0
// ============================================================================
module bec_arbiter
    import bec_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
)
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [c_NUM_REQ-1:0]         req,
    input  logic [c_NUM_REQ*c_X_W-1:0]   req_x,
    output logic [c_NUM_REQ-1:0]         gnt,
    output logic [c_X_W-1:0]             eng_x,
    output logic                         eng_start,
    input  logic                         eng_busy,
    input  logic [c_Y_W-1:0]             eng_y,
    output logic                         rsp_valid,
    output logic [c_ID_W-1:0]            rsp_id,
    output logic [c_Y_W-1:0]             rsp_y,
    output logic                         rsp_timeout,
    input  logic                         rsp_ready
);

    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_next;
    logic [c_ID_W-1:0]    r_ptr;
    logic [c_ID_W-1:0]    r_id;
    logic [c_ID_W-1:0]    w_winner;
    logic                 w_any;
    logic [c_NUM_REQ-1:0] r_gnt;
    logic [c_X_W-1:0]     r_eng_x;
    logic [c_Y_W-1:0]     r_acc;
    logic [c_TMR_W-1:0]   r_timer;
    logic                 r_seen;
    logic                 r_timeout;
    logic                 w_done;
    logic                 w_expire;

    bec_rr_pick u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    // Completion needs a busy period observed in an earlier RUN cycle.
    assign w_done   = r_seen && !eng_busy;
    assign w_expire = (r_timer == c_TMR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        eng_start = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = START;
                end
            end
            START: begin
                eng_start = 1'b1;
                w_next    = RUN;
            end
            RUN: begin
                if (w_done || w_expire) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_gnt     <= '0;
            r_eng_x   <= '0;
            r_acc     <= '0;
            r_timer   <= '0;
            r_seen    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= c_NUM_REQ'(1) << w_winner;
                        r_ptr   <= w_winner + 2'd1;
                        r_id    <= w_winner;
                        r_eng_x <= req_x[w_winner*c_X_W +: c_X_W];
                    end
                end
                START: begin
                    r_acc     <= '0;
                    r_timer   <= '0;
                    r_seen    <= 1'b0;
                    r_timeout <= 1'b0;
                end
                RUN: begin
                    r_acc   <= r_acc | eng_y;
                    r_timer <= r_timer + 8'd1;
                    if (eng_busy) begin
                        r_seen <= 1'b1;
                    end
                    if (w_expire && !w_done) begin
                        r_timeout <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_gnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign eng_x       = r_eng_x;
    assign rsp_id      = r_id;
    assign rsp_y       = r_acc;
    assign rsp_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bec_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bec_arbiter
// Description : Self-checking bench for bec_arbiter: vector table, random jobs
//               against a job-level reference model, reset corner case.
// Revision    : 1.0
// ============================================================================
module tb_bec_arbiter;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [71:0] req_x;
    logic [3:0]  gnt;
    logic [17:0] eng_x;
    logic        eng_start;
    logic        eng_busy;
    logic [38:0] eng_y;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [38:0] rsp_y;
    logic        rsp_timeout;
    logic        rsp_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;

    typedef struct {
        logic [3:0]  rq;
        int          dly;
        int          blen;
        int          ypos;
        logic [38:0] ypat;
        int          rdy;
        bit          drop;
        int          exp_id;
        logic        exp_to;
        int          exp_lat;
        logic [38:0] exp_y;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    bec_arbiter #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_x       (req_x),
        .gnt         (gnt),
        .eng_x       (eng_x),
        .eng_start   (eng_start),
        .eng_busy    (eng_busy),
        .eng_y       (eng_y),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_y       (rsp_y),
        .rsp_timeout (rsp_timeout),
        .rsp_ready   (rsp_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Round-robin: first requester found searching p, p+1, ... mod 4.
    function automatic int rr_pick(input logic [3:0] rq, input int p);
        for (int i = 0; i < 4; i++) begin
            if (rq[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    // Job outcome from the engine pattern: busy during RUN cycles [dly, dly+blen).
    function automatic void job_model(input int dly, input int blen, input int ypos,
                                      input logic [38:0] ypat, output int lat,
                                      output logic to, output logic [38:0] y);
        bit seen;
        bit b;
        seen = 0;
        y    = '0;
        to   = 1'b1;
        lat  = TMO;
        for (int k = 0; k < TMO; k++) begin
            b = (k >= dly) && (k < dly + blen);
            if (k == ypos) y = ypat;
            if (seen && !b) begin
                lat = k + 1;
                to  = 1'b0;
                return;
            end
            if (b) seen = 1;
        end
    endfunction

    task automatic run_job(input string tag, input logic [3:0] rq, input int dly,
                           input int blen, input int ypos, input logic [38:0] ypat,
                           input int rdy, input bit drop, input int exp_id,
                           input logic exp_to, input int exp_lat, input logic [38:0] exp_y);
        logic [95:0] rx;
        logic [3:0]  g;
        logic [3:0]  eg;
        logic [17:0] ex;
        logic [1:0]  rid;
        logic [38:0] ry;
        logic        rto;
        int glat;
        int lat;
        int extra;
        int unstable;
        rx    = {$urandom(), $urandom(), $urandom()};
        req_x = rx[71:0];
        req   = rq;
        glat  = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (eng_start) begin
                glat = i;
                break;
            end
        end
        chk({tag, " grant_latency"}, 64'(glat), 64'd1);
        g  = gnt;
        ex = eng_x;
        eg = 4'(1 << exp_id);
        chk({tag, " gnt"}, 64'(g), 64'(eg));
        chk({tag, " eng_x"}, 64'(ex), 64'(rx[exp_id*18 +: 18]));
        eng_busy = 1'b0;
        eng_y    = '0;
        lat      = -1;
        extra    = 0;
        unstable = 0;
        for (int n = 0; n < 300; n++) begin
            step();
            if (rsp_valid) begin
                lat = n;
                break;
            end
            if (eng_start) extra++;
            if (gnt !== g || eng_x !== ex) unstable++;
            if (drop && n == 1) req = 4'b0000;
            eng_busy = (n >= dly) && (n < dly + blen);
            eng_y    = (n == ypos) ? ypat : 39'd0;
        end
        eng_busy = 1'b0;
        eng_y    = '0;
        chk({tag, " run_cycles"}, 64'(lat), 64'(exp_lat));
        chk({tag, " extra_start"}, 64'(extra), 64'd0);
        if (lat < 0) begin
            req = 4'b0000;
            return;
        end
        rid = rsp_id;
        ry  = rsp_y;
        rto = rsp_timeout;
        chk({tag, " rsp_id"}, 64'(rid), 64'(exp_id));
        chk({tag, " rsp_y"}, 64'(ry), 64'(exp_y));
        chk({tag, " rsp_timeout"}, 64'(rto), 64'(exp_to));
        chk({tag, " gnt_in_resp"}, 64'(gnt), 64'(g));
        for (int w = 0; w < rdy; w++) begin
            step();
            if (!rsp_valid || rsp_id !== rid || rsp_y !== ry || rsp_timeout !== rto
                || gnt !== g || eng_start) unstable++;
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, " gnt_after_hs"}, 64'(gnt), 64'd0);
        chk({tag, " valid_after_hs"}, 64'(rsp_valid), 64'd0);
        chk({tag, " stability"}, 64'(unstable), 64'd0);
        req = 4'b0000;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        req_x     = '0;
        eng_busy  = 1'b0;
        eng_y     = '0;
        rsp_ready = 1'b0;
        step();
        step();
        chk("reset_ctrl", 64'({gnt, eng_start, rsp_valid, rsp_id, rsp_timeout}), 64'd0);
        chk("reset_data", 64'({eng_x, rsp_y}), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_no_req_gnt", 64'({gnt, eng_start, rsp_valid}), 64'd0);

        //          rq      dly blen ypos ypat             rdy drop id to lat  exp_y
        tbl[0]  = '{4'b1111, 1,  2,   2,  39'h1,           0,  0,  0, 0,  4,  39'h1};
        tbl[1]  = '{4'b1111, 0,  1,   0,  39'h2,           0,  0,  1, 0,  2,  39'h2};
        tbl[2]  = '{4'b1111, 2,  5,   9,  39'h4,           0,  0,  2, 0,  8,  39'h0};
        tbl[3]  = '{4'b1111, 0,  10,  10, 39'h8,           0,  0,  3, 0,  11, 39'h8};
        tbl[4]  = '{4'b1111, 0,  3,   0,  39'h0,           0,  0,  0, 0,  4,  39'h0};
        tbl[5]  = '{4'b0001, 0,  3,   1,  39'h20,          0,  0,  0, 0,  4,  39'h20};
        tbl[6]  = '{4'b1010, 0,  2,   0,  39'h0,           10, 0,  1, 0,  3,  39'h0};
        tbl[7]  = '{4'b0100, 0,  4,   3,  39'h40_0000_0000, 0,  1,  2, 0,  5,  39'h40_0000_0000};
        tbl[8]  = '{4'b1000, 0,  0,   63, 39'h10,          0,  0,  3, 1,  64, 39'h10};
        tbl[9]  = '{4'b0110, 0,  63,  0,  39'h3,           0,  0,  1, 0,  64, 39'h3};
        tbl[10] = '{4'b0011, 0,  100, 64, 39'h5,           0,  0,  0, 1,  64, 39'h0};
        tbl[11] = '{4'b0100, 0,  1,   5,  39'h7,           0,  0,  2, 0,  2,  39'h0};

        for (int i = 0; i < 12; i++) begin
            run_job($sformatf("vec%0d", i), tbl[i].rq, tbl[i].dly, tbl[i].blen, tbl[i].ypos,
                    tbl[i].ypat, tbl[i].rdy, tbl[i].drop, tbl[i].exp_id, tbl[i].exp_to,
                    tbl[i].exp_lat, tbl[i].exp_y);
            m_ptr = (tbl[i].exp_id + 1) % 4;
        end

        for (int j = 0; j < 20; j++) begin
            logic [3:0]  rq;
            logic [63:0] yt;
            logic [38:0] yp;
            logic [38:0] ey;
            logic        eto;
            int dly;
            int blen;
            int ypos;
            int rdy;
            int eid;
            int elat;
            bit drop;
            rq   = 4'($urandom_range(1, 15));
            dly  = int'($urandom_range(0, 4));
            blen = int'($urandom_range(0, 8));
            ypos = int'($urandom_range(0, 12));
            yt   = {$urandom(), $urandom()};
            yp   = yt[38:0];
            rdy  = int'($urandom_range(0, 3));
            drop = 1'($urandom_range(0, 1));
            eid  = rr_pick(rq, m_ptr);
            m_ptr = (eid + 1) % 4;
            job_model(dly, blen, ypos, yp, elat, eto, ey);
            run_job($sformatf("rnd%0d", j), rq, dly, blen, ypos, yp, rdy, drop,
                    eid, eto, elat, ey);
        end

        // Reset in the middle of a job: nothing may come out of it.
        begin
            int bad;
            req   = 4'b0010;
            req_x = {4{18'h2AB5}};
            step();
            chk("rst_job_start", 64'({gnt, eng_start}), 64'({4'b0010, 1'b1}));
            step();
            step();
            step();
            rst = 1'b1;
            #1;
            chk("rst_async_ctrl", 64'({gnt, eng_start, rsp_valid, rsp_id, rsp_timeout}), 64'd0);
            step();
            chk("rst_next_ctrl", 64'({gnt, eng_start, rsp_valid, rsp_id, rsp_timeout}), 64'd0);
            chk("rst_next_data", 64'({eng_x, rsp_y}), 64'd0);
            rst = 1'b0;
            req = 4'b0000;
            bad = 0;
            for (int k = 0; k < 5; k++) begin
                step();
                if (rsp_valid || gnt !== 4'b0000) bad++;
            end
            chk("rst_no_response", 64'(bad), 64'd0);
            req = 4'b0100;
            step();
            chk("rst_regrant", 64'({gnt, eng_start}), 64'({4'b0100, 1'b1}));
            rst = 1'b1;
            step();
            rst = 1'b0;
            req = 4'b0000;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bec_arbiter.md
BEC_ARBITER -- requirements
Module: bec_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set max engine-run cycles per job (legal range 4..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req  input  4  per-requester job request, level-held.
REQ-005 req_x  input  72  18-bit stimulus per requester; requester i uses bits [18i+17:18i].
REQ-006 gnt  output  4  one-hot grant, held for the whole job.
REQ-007 eng_x  output  18  stimulus to shared control engine.
REQ-008 eng_start  output  1  one-cycle job-start pulse to engine.
REQ-009 eng_busy  input  1  engine outside its idle state.
REQ-010 eng_y  input  39  engine control outputs.
REQ-011 rsp_valid  output  1  job result valid.
REQ-012 rsp_id  output  2  requester index of result.
REQ-013 rsp_y  output  39  OR-accumulated eng_y over the job.
REQ-014 rsp_timeout  output  1  job ended by timeout.
REQ-015 rsp_ready  input  1  result consumer ready.

Function
REQ-016 FSM SHALL have states IDLE, START, RUN, RESP.
REQ-017 IDLE: when req nonzero, select winner by round-robin from pointer ptr; next cycle gnt=onehot(winner), state START.
REQ-018 Round-robin: search order ptr, ptr+1, ... mod 4; after selection ptr SHALL become winner+1 mod 4.
REQ-019 START: eng_start=1 for exactly one cycle; eng_x=req_x slice of winner, latched at grant and held constant until RESP exit; clear rsp_y accumulator and timer; next RUN.
REQ-020 RUN: each cycle accumulator |= eng_y; timer increments (8-bit).
REQ-021 RUN completes when eng_busy was seen high at least once and is now low -> RESP, rsp_timeout=0.
REQ-022 If timer reaches TIMEOUT-1 before completion -> RESP, rsp_timeout=1; completion and timeout in the same cycle -> completion wins.
REQ-023 RESP: rsp_valid=1, rsp_id, rsp_y, rsp_timeout stable until rsp_valid&&rsp_ready; on that cycle gnt clears, state IDLE.
REQ-024 Earliest re-grant SHALL be the cycle after handshake; zero-idle back-to-back not required.
REQ-025 Deassertion of req by the granted requester mid-job SHALL NOT abort the job.
REQ-026 eng_start SHALL never assert outside START; gnt SHALL be zero in IDLE.
REQ-027 Latency req->gnt 1 cycle, gnt->eng_start same cycle.

Reset
REQ-028 On rst: state IDLE, ptr=0, gnt=0, eng_x=0, eng_start=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_timeout=0, timer=0.
REQ-029 rst mid-job SHALL abandon the job without producing a response.

Structure
REQ-030 Shared package SHALL hold state enum, requester count (4), stimulus width (18), output width (39).
REQ-031 One sub-module bec_rr_pick (combinational 4-way round-robin picker: req, ptr -> winner, any) SHALL be used.

Verification
REQ-032 req=0001, engine busy 3 cycles then idle, eng_y bit5 pulsed once -> gnt=0001, one eng_start, rsp_id=0, rsp_y bit5=1, rsp_timeout=0.
REQ-033 req=1111 held, four jobs -> grant order 0,1,2,3, then 0 again.
REQ-034 eng_busy never asserts, TIMEOUT=64 -> rsp_valid 64 cycles after RUN entry, rsp_timeout=1.
REQ-035 rsp_ready low 10 cycles in RESP -> rsp_* stable, no new grant until handshake.
REQ-036 Requester 2 drops req during RUN -> job completes, rsp_id=2.
REQ-037 rst pulsed during RUN -> all outputs zero next cycle, no rsp_valid; after release req=0100 -> gnt=0100.
